// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture
// Capture engine for OV7670-class parallel camera sensors. Sensor bytes
// arriving on d (qualified by href, framed by vsync) are paired or selected
// according to the pixel mode latched at frame start. They are optionally
// decimated 2x2 and written to a frame buffer as one addr/dout/we write per
// pixel.
//
// Ports:
//   pclk, rst_n           sensor pixel clock, synchronous active-low reset
//   vsync, href, d        sensor frame sync, line valid and data byte
//   mode, decim           pixel mode and 2x2 decimation, sampled at frame start
//   addr, dout, we        registered frame-buffer write port
//   frame_start/done      one-cycle frame boundary strobes
//   frame_cnt             completed frame counter (wrapping)
//   line_err, ovf         sticky geometry / address-overflow flags, cleared
//                         at frame start
module cam_pixel_capture #(
    parameter int ADDR_W   = 19,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 8
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        mode,
    input  logic              decim,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_start,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              line_err,
    output logic              ovf
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1) + 1;
    localparam int LINE_W = $clog2(V_ACTIVE + 1) + 1;
    localparam logic [ADDR_W:0] LIMIT_FULL  = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W:0] LIMIT_DECIM = (ADDR_W + 1)'((H_ACTIVE / 2) * (V_ACTIVE / 2));
    localparam logic [COL_W-1:0] COL_TARGET = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_MAX    = '1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_VBLANK,
        ST_ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic               href_q, href_d;
    logic [7:0]         hi_q, hi_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LINE_W-1:0]  line_q, line_d;
    // One bit wider than addr so a limit of 2^ADDR_W is still representable.
    logic [ADDR_W:0]    addr_cnt_q, addr_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               decim_q, decim_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        dout_q, dout_d;
    logic               we_q, we_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               line_err_q, line_err_d;
    logic               ovf_q, ovf_d;

    logic               pix_valid;
    logic [15:0]        pix_data;
    logic [ADDR_W:0]    limit;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q       <= ST_SYNC;
            phase_q       <= 1'b0;
            href_q        <= 1'b0;
            hi_q          <= '0;
            col_q         <= '0;
            line_q        <= '0;
            addr_cnt_q    <= '0;
            mode_q        <= '0;
            decim_q       <= 1'b0;
            addr_q        <= '0;
            dout_q        <= '0;
            we_q          <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            line_err_q    <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            href_q        <= href_d;
            hi_q          <= hi_d;
            col_q         <= col_d;
            line_q        <= line_d;
            addr_cnt_q    <= addr_cnt_d;
            mode_q        <= mode_d;
            decim_q       <= decim_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            we_q          <= we_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            line_err_q    <= line_err_d;
            ovf_q         <= ovf_d;
        end
    end

    // SYNC waits for a vsync high so a frame interrupted by reset is never captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:   if (vsync)  state_d = ST_VBLANK;
            ST_VBLANK: if (!vsync) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vsync)  state_d = ST_VBLANK;
            default:   state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        phase_d       = phase_q;
        href_d        = 1'b0;
        hi_d          = hi_q;
        col_d         = col_q;
        line_d        = line_q;
        addr_cnt_d    = addr_cnt_q;
        mode_d        = mode_q;
        decim_d       = decim_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        we_d          = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        line_err_d    = line_err_q;
        ovf_d         = ovf_q;
        pix_valid     = 1'b0;
        pix_data      = '0;
        limit         = decim_q ? LIMIT_DECIM : LIMIT_FULL;

        case (state_q)
            ST_VBLANK: begin
                if (!vsync) begin
                    frame_start_d = 1'b1;
                    mode_d        = mode;
                    decim_d       = decim;
                    addr_d        = '0;
                    addr_cnt_d    = '0;
                    col_d         = '0;
                    line_d        = '0;
                    phase_d       = 1'b0;
                    line_err_d    = 1'b0;
                    ovf_d         = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (vsync) begin
                    // Any half-formed pixel is simply dropped with the frame.
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                    phase_d      = 1'b0;
                end else begin
                    href_d = href;
                    if (href) begin
                        phase_d = ~phase_q;
                        case (mode_q)
                            2'd0: begin
                                if (phase_q) begin
                                    pix_valid = 1'b1;
                                    pix_data  = {4'b0000, hi_q[7:4], hi_q[2:0], d[7], d[4:1]};
                                end else begin
                                    hi_d = d;
                                end
                            end
                            2'd1: begin
                                if (phase_q) begin
                                    pix_valid = 1'b1;
                                    pix_data  = {hi_q, d};
                                end else begin
                                    hi_d = d;
                                end
                            end
                            2'd2: begin
                                if (!phase_q) begin
                                    pix_valid = 1'b1;
                                    pix_data  = {8'h00, d};
                                end
                            end
                            default: begin
                                pix_valid = 1'b1;
                                pix_data  = {8'h00, d};
                            end
                        endcase

                        if (pix_valid) begin
                            // Saturate so an overlong line never wraps back onto H_ACTIVE.
                            if (col_q != COL_MAX) col_d = col_q + COL_W'(1);
                            if (!decim_q || (!col_q[0] && !line_q[0])) begin
                                if (addr_cnt_q == limit) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    we_d       = 1'b1;
                                    addr_d     = addr_cnt_q[ADDR_W-1:0];
                                    dout_d     = pix_data;
                                    addr_cnt_d = addr_cnt_q + (ADDR_W + 1)'(1);
                                end
                            end
                        end
                    end else begin
                        phase_d = 1'b0;
                        if (href_q) begin
                            if (col_q != COL_TARGET) line_err_d = 1'b1;
                            col_d  = '0;
                            line_d = line_q + LINE_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign addr        = addr_q;
    assign dout        = dout_q;
    assign we          = we_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_err    = line_err_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Testbench for cam_pixel_capture with a 4x4 active geometry. Writes are
// collected by a monitor into a queue and compared with hand-computed
// expectations for each frame.
module tb_cam_pixel_capture;

    localparam int ADDR_W   = 8;
    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 4;
    localparam int CNT_W    = 8;

    logic              pclk = 1'b0;
    logic              rst_n;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [1:0]        mode;
    logic              decim;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
    logic              we;
    logic              frame_start;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_cnt;
    logic              line_err;
    logic              ovf;

    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;
    logic [31:0] wr_q[$];

    cam_pixel_capture #(
        .ADDR_W(ADDR_W),
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .vsync(vsync),
        .href(href),
        .d(d),
        .mode(mode),
        .decim(decim),
        .addr(addr),
        .dout(dout),
        .we(we),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .line_err(line_err),
        .ovf(ovf)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (we) wr_q.push_back({8'h00, addr, dout});
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] b);
        vsync = v;
        href  = h;
        d     = b;
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input logic [7:0] b0, input logic [7:0] b1, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? b0 : b1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic dc);
        mode  = m;
        decim = dc;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("frame_done width", frame_done, 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("frame_start", frame_start, 1);
        checkOutput("start line_err clr", line_err, 0);
        checkOutput("start ovf clr", ovf, 0);
        checkOutput("start addr clr", addr, 0);
        checkOutput("start frame_cnt", frame_cnt, exp_frames);
        wr_q.delete();
    endtask

    task automatic end_frame(input logic h, input logic [7:0] b);
        applyStimulus(1'b1, h, b);
        exp_frames++;
        checkOutput("frame_done", frame_done, 1);
        checkOutput("frame_done no start", frame_start, 0);
        checkOutput("frame_cnt", frame_cnt, exp_frames);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [15:0] dout_even,
                                input logic [15:0] dout_odd);
        checkOutput({tag, " count"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            checkOutput({tag, " addr"}, wr_q[i][23:16], i);
            checkOutput({tag, " dout"}, wr_q[i][15:0], (i % 2 == 0) ? dout_even : dout_odd);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, " we"}, we, 0);
        checkOutput({tag, " addr"}, addr, 0);
        checkOutput({tag, " dout"}, dout, 0);
        checkOutput({tag, " frame_cnt"}, frame_cnt, 0);
        checkOutput({tag, " flags"}, {frame_start, frame_done, line_err, ovf}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b1;
        href  = 1'b0;
        d     = 8'h00;
        mode  = 2'd0;
        decim = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // RGB565 -> RGB444: F81F is pure red + pure blue.
        start_frame(2'd0, 1'b0);
        send_line(8'hF8, 8'h1F, 8);
        send_line(8'hF8, 8'h1F, 8);
        check_writes("mode0", 8, 16'h0F0F, 16'h0F0F);
        checkOutput("mode0 line_err", line_err, 0);
        end_frame(1'b0, 8'h00);

        start_frame(2'd1, 1'b0);
        send_line(8'h12, 8'h34, 8);
        send_line(8'h12, 8'h34, 8);
        check_writes("mode1", 8, 16'h1234, 16'h1234);
        end_frame(1'b0, 8'h00);

        start_frame(2'd2, 1'b0);
        send_line(8'hAA, 8'h55, 8);
        send_line(8'hAA, 8'h55, 8);
        check_writes("mode2", 8, 16'h00AA, 16'h00AA);
        checkOutput("mode2 line_err", line_err, 0);
        end_frame(1'b0, 8'h00);

        // Raw bytes: 8 pixels on a 4-pixel line is a geometry error.
        start_frame(2'd3, 1'b0);
        send_line(8'h5A, 8'hC3, 8);
        check_writes("mode3", 8, 16'h005A, 16'h00C3);
        checkOutput("mode3 line_err", line_err, 1);
        end_frame(1'b0, 8'h00);
        checkOutput("line_err sticky", line_err, 1);

        // Decimation keeps columns 0,2 of lines 0,2; line value in b0 tags the source line.
        start_frame(2'd3, 1'b1);
        send_line(8'h10, 8'hFF, 4);
        send_line(8'h20, 8'hFF, 4);
        send_line(8'h30, 8'hFF, 4);
        send_line(8'h40, 8'hFF, 4);
        checkOutput("decim count", wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            checkOutput("decim w0", wr_q[0][23:0], 24'h00_0010);
            checkOutput("decim w1", wr_q[1][23:0], 24'h01_0010);
            checkOutput("decim w2", wr_q[2][23:0], 24'h02_0030);
            checkOutput("decim w3", wr_q[3][23:0], 24'h03_0030);
        end
        checkOutput("decim ovf", ovf, 0);
        checkOutput("decim line_err", line_err, 0);
        end_frame(1'b0, 8'h00);

        // Short line with a trailing odd byte; the next line must stay aligned.
        start_frame(2'd1, 1'b0);
        send_line(8'h12, 8'h34, 7);
        checkOutput("short line_err", line_err, 1);
        send_line(8'h12, 8'h34, 8);
        check_writes("short", 7, 16'h1234, 16'h1234);
        end_frame(1'b0, 8'h00);

        // Five full lines into a 16-pixel buffer: the fifth line overflows.
        start_frame(2'd1, 1'b0);
        repeat (5) send_line(8'h12, 8'h34, 8);
        check_writes("ovf", 16, 16'h1234, 16'h1234);
        checkOutput("ovf flag", ovf, 1);
        checkOutput("ovf addr hold", addr, 15);
        checkOutput("ovf line_err", line_err, 0);
        end_frame(1'b0, 8'h00);

        // Reset mid-line, then a line before any vsync must not be captured.
        start_frame(2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h12);
        applyStimulus(1'b0, 1'b1, 8'h34);
        applyStimulus(1'b0, 1'b1, 8'h12);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h34);
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        wr_q.delete();
        exp_frames = 0;
        send_line(8'h12, 8'h34, 8);
        checkOutput("no write after reset", wr_q.size(), 0);
        start_frame(2'd1, 1'b0);
        send_line(8'h56, 8'h78, 8);
        check_writes("post reset", 4, 16'h5678, 16'h5678);
        end_frame(1'b0, 8'h00);

        // Mode change mid-frame is ignored; vsync rising mid-pixel writes nothing.
        start_frame(2'd0, 1'b0);
        send_line(8'hF8, 8'h1F, 8);
        mode = 2'd1;
        send_line(8'hF8, 8'h1F, 8);
        applyStimulus(1'b0, 1'b1, 8'hF8);
        end_frame(1'b1, 8'h1F);
        applyStimulus(1'b1, 1'b0, 8'h00);
        check_writes("toggle", 8, 16'h0F0F, 16'h0F0F);
        start_frame(2'd1, 1'b0);
        send_line(8'hF8, 8'h1F, 8);
        check_writes("next mode1", 4, 16'hF81F, 16'hF81F);
        end_frame(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
